piece_drop: RTL and testbench

- Upstream board-state stage for the connect-four game.
- Accepts a player's column selection and drop request, and animates the piece falling one row at a time.
- Writes the landed piece into the current player's board and alternates turns.
- Owns the red and green 16x16 occupancy boards consumed by the win detector. Takes the detector's 2-bit win code back so it can lock out further moves.

---
 rtl/piece_drop.sv | 116 +++++++++++
 tb/tb_piece_drop.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/piece_drop.sv
// Connect-four board-state stage: accepts column drops, animates the falling
// piece row by row, writes it into the mover's board and alternates turns.
module piece_drop #(
    parameter int FALL_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        col_sel,
    input  logic              drop,
    input  logic [1:0]        win,
    output logic [15:0][15:0] red,
    output logic [15:0][15:0] green,
    output logic              turn,
    output logic              busy,
    output logic              fall_active,
    output logic [3:0]        fall_row,
    output logic [3:0]        fall_col,
    output logic              reject,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FALL   = 3'd1,
        LAND   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4
    } state_t;

    localparam logic [7:0] LAST_TICK = 8'(FALL_TICKS - 1);

    state_t     st;
    logic [7:0] tick;
    logic [3:0] next_row;
    logic       top_full;
    logic       below_full;

    assign state      = st;
    assign next_row   = fall_row + 4'd1;
    assign top_full   = red[0][col_sel] | green[0][col_sel];
    // Only meaningful when fall_row < 15; the row-15 case is caught first.
    assign below_full = red[next_row][fall_col] | green[next_row][fall_col];

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= IDLE;
            tick        <= 8'd0;
            red         <= '0;
            green       <= '0;
            turn        <= 1'b0;
            busy        <= 1'b0;
            fall_active <= 1'b0;
            fall_row    <= 4'd0;
            fall_col    <= 4'd0;
            reject      <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (st)
                IDLE: begin
                    // A pending win code takes priority over any drop request.
                    if (win != 2'b00) begin
                        st <= LOCKED;
                    end else if (drop) begin
                        if (top_full) begin
                            reject <= 1'b1;
                        end else begin
                            fall_col    <= col_sel;
                            fall_row    <= 4'd0;
                            tick        <= 8'd0;
                            busy        <= 1'b1;
                            fall_active <= 1'b1;
                            st          <= FALL;
                        end
                    end
                end
                FALL: begin
                    if (tick == LAST_TICK) begin
                        if (fall_row == 4'd15 || below_full) begin
                            fall_active <= 1'b0;
                            st          <= LAND;
                        end else begin
                            fall_row <= next_row;
                            tick     <= 8'd0;
                        end
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                LAND: begin
                    if (!turn) red[fall_row][fall_col]   <= 1'b1;
                    else       green[fall_row][fall_col] <= 1'b1;
                    turn <= ~turn;
                    tick <= 8'd0;
                    st   <= SETTLE;
                end
                SETTLE: begin
                    // Two cycles so the detector's result reflects the new piece.
                    if (tick == 8'd1) begin
                        tick <= 8'd0;
                        busy <= 1'b0;
                        st   <= IDLE;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                LOCKED: begin
                    st <= LOCKED;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_drop.sv
// Directed and random drops on piece_drop, checked against a board model that
// computes landing rows and timing from the game rules.
module tb_piece_drop;
    localparam int FT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        col_sel;
    logic              drop;
    logic [1:0]        win;
    logic [15:0][15:0] red;
    logic [15:0][15:0] green;
    logic              turn;
    logic              busy;
    logic              fall_active;
    logic [3:0]        fall_row;
    logic [3:0]        fall_col;
    logic              reject;
    logic [2:0]        state;

    int n_checks = 0;
    int n_fails  = 0;
    int brd [16][16];   // 0 empty, 1 red, 2 green
    int m_turn;

    always #5 clk = ~clk;

    piece_drop #(.FALL_TICKS(FT)) dut (
        .clk(clk), .reset(reset), .col_sel(col_sel), .drop(drop), .win(win),
        .red(red), .green(green), .turn(turn), .busy(busy),
        .fall_active(fall_active), .fall_row(fall_row), .fall_col(fall_col),
        .reject(reject), .state(state)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] exp_board(input int who);
        logic [255:0] v;
        v = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                v[r*16 + c] = (brd[r][c] == who);
        return v;
    endfunction

    function automatic int land_row(input int c);
        for (int r = 0; r < 16; r++)
            if (brd[r][c] != 0) return r - 1;
        return 15;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                brd[r][c] = 0;
        m_turn = 0;
    endtask

    task automatic check_boards(input string tag);
        check({tag, "_red"}, red, exp_board(1));
        check({tag, "_green"}, green, exp_board(2));
        check({tag, "_turn"}, 256'(turn), 256'(m_turn));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_red"}, red, 256'(0));
        check({tag, "_green"}, green, 256'(0));
        check({tag, "_turn"}, 256'(turn), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_fall_active"}, 256'(fall_active), 256'(0));
        check({tag, "_fall_row"}, 256'(fall_row), 256'(0));
        check({tag, "_fall_col"}, 256'(fall_col), 256'(0));
        check({tag, "_reject"}, 256'(reject), 256'(0));
        check({tag, "_state_idle"}, 256'(state), 256'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop  = 1'b0;
        tick();
        reset = 1'b0;
        clear_model();
    endtask

    // Accepted drop: follows the piece through every FALL cycle, LAND and SETTLE.
    task automatic run_drop(input int col, input bit disturb);
        int r;
        int kmax;
        r = land_row(col);
        kmax = (r + 1) * FT;
        col_sel = 4'(col);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            check("fall_active", 256'(fall_active), 256'(1));
            check("fall_row", 256'(fall_row), 256'((k - 1) / FT));
            check("fall_col", 256'(fall_col), 256'(col));
            check("fall_busy", 256'(busy), 256'(1));
            if (disturb && k == 3) begin
                drop = 1'b1;
                col_sel = 4'(col + 1);
            end
            if (disturb && k == 5) drop = 1'b0;
            tick();
        end
        check("land_fall_active", 256'(fall_active), 256'(0));
        check("land_busy", 256'(busy), 256'(1));
        check_boards("land_pre");
        tick();
        brd[r][col] = m_turn + 1;
        m_turn ^= 1;
        check_boards("landed");
        check("no_overlap", red & green, 256'(0));
        check("settle1_busy", 256'(busy), 256'(1));
        tick();
        check("settle2_busy", 256'(busy), 256'(1));
        tick();
        check("idle_busy", 256'(busy), 256'(0));
        check("idle_state", 256'(state), 256'(0));
        check("landed_col", 256'(fall_col), 256'(col));
    endtask

    task automatic run_reject(input int col);
        col_sel = 4'(col);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check("reject_pulse", 256'(reject), 256'(1));
        check("reject_busy", 256'(busy), 256'(0));
        check("reject_fall_active", 256'(fall_active), 256'(0));
        check_boards("reject");
        tick();
        check("reject_clear", 256'(reject), 256'(0));
        check("reject_busy2", 256'(busy), 256'(0));
    endtask

    task automatic do_drop(input int col);
        if (land_row(col) < 0) run_reject(col);
        else run_drop(col, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drop = 1'b0;
        col_sel = 4'd0;
        win = 2'b00;
        clear_model();
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        run_drop(5, 1'b0);
        run_drop(5, 1'b0);
        run_drop(7, 1'b1);

        for (int i = 0; i < 16; i++) run_drop(3, 1'b0);
        run_reject(3);

        repeat (12) do_drop(int'($urandom_range(0, 15)));

        // Reset in the seventh FALL cycle of a fresh drop.
        col_sel = 4'd9;
        drop = 1'b1;
        tick();
        drop = 1'b0;
        repeat (6) tick();
        check("mid_fall_active", 256'(fall_active), 256'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        check_all_zero("mid_fall_reset");
        repeat (3) tick();
        check_all_zero("mid_fall_after");

        run_drop(0, 1'b0);
        run_drop(11, 1'b0);
        win = 2'b01;
        tick();
        check("locked_state", 256'(state), 256'(4));
        col_sel = 4'd0;
        drop = 1'b1;
        repeat (4) begin
            tick();
            check("locked_fall_active", 256'(fall_active), 256'(0));
            check("locked_busy", 256'(busy), 256'(0));
            check("locked_reject", 256'(reject), 256'(0));
            check_boards("locked");
        end
        drop = 1'b0;
        win = 2'b00;
        tick();
        check("still_locked", 256'(state), 256'(4));
        do_reset();
        check_all_zero("unlock_reset");
        run_drop(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
